// File: rtl/sys_ctrl_gen.sv
// Command controller for the UART system: decodes RX frames into RF write/read and ALU commands,
// streams read data and ALU results to the TX FIFO LSB chunk first, with per-state timeout.
module sys_ctrl_gen #(
  parameter int unsigned            DATA_WIDTH     = 8,
  parameter int unsigned            ADDR_WIDTH     = 4,
  parameter int unsigned            FUN_WIDTH      = 4,
  parameter int unsigned            RESULT_CHUNKS  = 2,
  parameter int unsigned            TIMEOUT_CYCLES = 1024,
  parameter int unsigned            OPA_ADDR       = 0,
  parameter int unsigned            OPB_ADDR       = 1,
  parameter logic [DATA_WIDTH-1:0]  CMD_WR         = 'hAA,
  parameter logic [DATA_WIDTH-1:0]  CMD_RD         = 'hBB,
  parameter logic [DATA_WIDTH-1:0]  CMD_ALU_OP     = 'hCC,
  parameter logic [DATA_WIDTH-1:0]  CMD_ALU_NOP    = 'hDD
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [DATA_WIDTH-1:0]               i_uart_rx_data,
  input  logic                                i_uart_rx_vld,
  input  logic [DATA_WIDTH-1:0]               i_rf_rd_data,
  input  logic                                i_rf_rd_data_vld,
  input  logic [RESULT_CHUNKS*DATA_WIDTH-1:0] i_alu_out,
  input  logic                                i_alu_out_vld,
  input  logic                                i_fifo_full,
  output logic                                o_rf_wr_en,
  output logic                                o_rf_rd_en,
  output logic [ADDR_WIDTH-1:0]               o_rf_address,
  output logic [DATA_WIDTH-1:0]               o_rf_wr_data,
  output logic                                o_alu_en,
  output logic [FUN_WIDTH-1:0]                o_alu_fun,
  output logic                                o_clkg_en,
  output logic                                o_clkdiv_en,
  output logic [DATA_WIDTH-1:0]               o_uart_tx_data,
  output logic                                o_uart_tx_vld,
  output logic                                o_cmd_err,
  output logic                                o_busy
);

  localparam int unsigned ResW    = RESULT_CHUNKS * DATA_WIDTH;
  localparam int unsigned CntW    = $clog2(RESULT_CHUNKS + 1);
  localparam int unsigned TmoW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned TmoLast = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StOpA, StOpB, StAluFn, StAluWait, StTxSend
  } state_e;

  state_e                r_state, w_state_d;
  logic [TmoW-1:0]       r_tmo_cnt, w_tmo_cnt_d;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_d;
  logic [ResW-1:0]       r_result, w_result_d;
  logic [CntW-1:0]       r_chunks, w_chunks_d;

  logic                  r_rf_wr_en, w_rf_wr_en_d, r_rf_rd_en, w_rf_rd_en_d;
  logic [ADDR_WIDTH-1:0] r_rf_address, w_rf_address_d;
  logic [DATA_WIDTH-1:0] r_rf_wr_data, w_rf_wr_data_d, r_tx_data, w_tx_data_d;
  logic                  r_alu_en, w_alu_en_d, r_clkg_en, w_clkg_en_d, r_clkdiv_en;
  logic [FUN_WIDTH-1:0]  r_alu_fun, w_alu_fun_d;
  logic                  r_tx_vld, w_tx_vld_d, r_cmd_err, w_cmd_err_d, r_busy;
  logic                  w_frame_acc, w_counting, w_tmo_hit;

  always_comb begin
    w_state_d       = r_state;
    w_wr_addr_d     = r_wr_addr;
    w_result_d      = r_result;
    w_chunks_d      = r_chunks;
    w_rf_wr_en_d    = 1'b0;
    w_rf_rd_en_d    = 1'b0;
    w_rf_address_d  = r_rf_address;
    w_rf_wr_data_d  = r_rf_wr_data;
    w_alu_en_d      = 1'b0;
    w_alu_fun_d     = r_alu_fun;
    w_clkg_en_d     = r_clkg_en;
    w_tx_data_d     = r_tx_data;
    w_tx_vld_d      = 1'b0;
    w_cmd_err_d     = 1'b0;
    w_frame_acc     = 1'b0;

    case (r_state)
      StIdle: if (i_uart_rx_vld) begin
        w_frame_acc = 1'b1;
        if (i_uart_rx_data == CMD_WR) begin
          w_state_d = StWrAddr;
        end else if (i_uart_rx_data == CMD_RD) begin
          w_state_d = StRdAddr;
        end else if (i_uart_rx_data == CMD_ALU_OP) begin
          w_state_d = StOpA;
        end else if (i_uart_rx_data == CMD_ALU_NOP) begin
          w_state_d   = StAluFn;
          w_clkg_en_d = 1'b1;
        end else begin
          w_cmd_err_d = 1'b1;
        end
      end
      StWrAddr: if (i_uart_rx_vld) begin
        w_frame_acc = 1'b1;
        w_wr_addr_d = i_uart_rx_data[ADDR_WIDTH-1:0];
        w_state_d   = StWrData;
      end
      StWrData: if (i_uart_rx_vld) begin
        w_frame_acc    = 1'b1;
        w_rf_wr_en_d   = 1'b1;
        w_rf_address_d = r_wr_addr;
        w_rf_wr_data_d = i_uart_rx_data;
        w_state_d      = StIdle;
      end
      StRdAddr: if (i_uart_rx_vld) begin
        w_frame_acc    = 1'b1;
        w_rf_rd_en_d   = 1'b1;
        w_rf_address_d = i_uart_rx_data[ADDR_WIDTH-1:0];
        w_state_d      = StRdWait;
      end
      StRdWait: begin
        w_cmd_err_d = i_uart_rx_vld;
        if (i_rf_rd_data_vld) begin
          w_result_d                 = '0;
          w_result_d[DATA_WIDTH-1:0] = i_rf_rd_data;
          w_chunks_d                 = CntW'(1);
          w_state_d                  = StTxSend;
        end
      end
      StOpA, StOpB: if (i_uart_rx_vld) begin
        w_frame_acc    = 1'b1;
        w_rf_wr_en_d   = 1'b1;
        w_rf_wr_data_d = i_uart_rx_data;
        if (r_state == StOpA) begin
          w_rf_address_d = ADDR_WIDTH'(OPA_ADDR);
          w_state_d      = StOpB;
        end else begin
          w_rf_address_d = ADDR_WIDTH'(OPB_ADDR);
          w_clkg_en_d    = 1'b1;
          w_state_d      = StAluFn;
        end
      end
      StAluFn: if (i_uart_rx_vld) begin
        w_frame_acc = 1'b1;
        w_alu_en_d  = 1'b1;
        w_alu_fun_d = i_uart_rx_data[FUN_WIDTH-1:0];
        w_state_d   = StAluWait;
      end
      StAluWait: begin
        w_cmd_err_d = i_uart_rx_vld;
        if (i_alu_out_vld) begin
          w_result_d  = i_alu_out;
          w_chunks_d  = CntW'(RESULT_CHUNKS);
          w_clkg_en_d = 1'b0;
          w_state_d   = StTxSend;
        end
      end
      StTxSend: begin
        w_cmd_err_d = i_uart_rx_vld;
        if (!i_fifo_full) begin
          w_tx_vld_d  = 1'b1;
          w_tx_data_d = r_result[DATA_WIDTH-1:0];
          w_result_d  = r_result >> DATA_WIDTH;
          w_chunks_d  = r_chunks - CntW'(1);
          if (r_chunks == CntW'(1)) w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Timeout only fires when nothing else moved the FSM this cycle.
    w_counting = (r_state != StIdle) && (r_state != StTxSend);
    w_tmo_hit  = (TIMEOUT_CYCLES != 0) && w_counting && !w_frame_acc &&
                 (w_state_d == r_state) && (r_tmo_cnt == TmoW'(TmoLast));
    if (w_tmo_hit) begin
      w_state_d   = StIdle;
      w_cmd_err_d = 1'b1;
      w_clkg_en_d = 1'b0;
    end

    if ((w_state_d != r_state) || w_frame_acc) w_tmo_cnt_d = '0;
    else if (w_counting)                        w_tmo_cnt_d = r_tmo_cnt + TmoW'(1);
    else                                        w_tmo_cnt_d = r_tmo_cnt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_tmo_cnt    <= '0;
      r_wr_addr    <= '0;
      r_result     <= '0;
      r_chunks     <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_rd_en   <= 1'b0;
      r_rf_address <= '0;
      r_rf_wr_data <= '0;
      r_alu_en     <= 1'b0;
      r_alu_fun    <= '0;
      r_clkg_en    <= 1'b0;
      r_clkdiv_en  <= 1'b0;
      r_tx_data    <= '0;
      r_tx_vld     <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_tmo_cnt    <= w_tmo_cnt_d;
      r_wr_addr    <= w_wr_addr_d;
      r_result     <= w_result_d;
      r_chunks     <= w_chunks_d;
      r_rf_wr_en   <= w_rf_wr_en_d;
      r_rf_rd_en   <= w_rf_rd_en_d;
      r_rf_address <= w_rf_address_d;
      r_rf_wr_data <= w_rf_wr_data_d;
      r_alu_en     <= w_alu_en_d;
      r_alu_fun    <= w_alu_fun_d;
      r_clkg_en    <= w_clkg_en_d;
      r_clkdiv_en  <= 1'b1;
      r_tx_data    <= w_tx_data_d;
      r_tx_vld     <= w_tx_vld_d;
      r_cmd_err    <= w_cmd_err_d;
      r_busy       <= (w_state_d != StIdle);
    end
  end

  assign o_rf_wr_en     = r_rf_wr_en;
  assign o_rf_rd_en     = r_rf_rd_en;
  assign o_rf_address   = r_rf_address;
  assign o_rf_wr_data   = r_rf_wr_data;
  assign o_alu_en       = r_alu_en;
  assign o_alu_fun      = r_alu_fun;
  assign o_clkg_en      = r_clkg_en;
  assign o_clkdiv_en    = r_clkdiv_en;
  assign o_uart_tx_data = r_tx_data;
  assign o_uart_tx_vld  = r_tx_vld;
  assign o_cmd_err      = r_cmd_err;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_sys_ctrl_gen.sv
// Directed bench for sys_ctrl_gen: write, read, ALU with backpressure, bad opcode, timeout, reset.
module tb_sys_ctrl_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data, rf_rd_data;
  logic        rx_vld, rf_rd_vld, alu_vld, fifo_full;
  logic [15:0] alu_out;
  logic        rf_wr_en, rf_rd_en, alu_en, clkg_en, clkdiv_en, tx_vld, cmd_err, busy;
  logic [3:0]  rf_addr, alu_fun;
  logic [7:0]  rf_wr_data, tx_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_wr   = 0;
  int n_tx   = 0;
  int n_alu  = 0;

  always #5 clk = ~clk;

  sys_ctrl_gen dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_uart_rx_data   (rx_data),
    .i_uart_rx_vld    (rx_vld),
    .i_rf_rd_data     (rf_rd_data),
    .i_rf_rd_data_vld (rf_rd_vld),
    .i_alu_out        (alu_out),
    .i_alu_out_vld    (alu_vld),
    .i_fifo_full      (fifo_full),
    .o_rf_wr_en       (rf_wr_en),
    .o_rf_rd_en       (rf_rd_en),
    .o_rf_address     (rf_addr),
    .o_rf_wr_data     (rf_wr_data),
    .o_alu_en         (alu_en),
    .o_alu_fun        (alu_fun),
    .o_clkg_en        (clkg_en),
    .o_clkdiv_en      (clkdiv_en),
    .o_uart_tx_data   (tx_data),
    .o_uart_tx_vld    (tx_vld),
    .o_cmd_err        (cmd_err),
    .o_busy           (busy)
  );

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rf_wr_en) n_wr++;
    if (tx_vld)   n_tx++;
    if (alu_en)   n_alu++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    tick();
    rx_vld  = 1'b0;
  endtask

  int wr_snap, alu_snap, err_at;

  initial begin
    rst = 1'b1; rx_data = '0; rx_vld = 1'b0; rf_rd_data = '0; rf_rd_vld = 1'b0;
    alu_out = '0; alu_vld = 1'b0; fifo_full = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_clkdiv", clkdiv_en, 0);
    check("rst_outs", {rf_wr_en, rf_rd_en, alu_en, clkg_en, tx_vld, cmd_err}, 0);
    rst = 1'b0;
    tick();
    check("clkdiv_on", clkdiv_en, 1);

    // RF write AA,05,3C
    send(8'hAA);
    check("wr_busy", busy, 1);
    send(8'h05);
    send(8'h3C);
    check("wr_en", rf_wr_en, 1);
    check("wr_addr", rf_addr, 4'h5);
    check("wr_data", rf_wr_data, 8'h3C);
    check("wr_busy_low", busy, 0);
    tick();
    check("wr_en_pulse", rf_wr_en, 0);

    // RF read BB,05; a stray frame during RD_WAIT is dropped with an error
    send(8'hBB);
    send(8'h05);
    check("rd_en", rf_rd_en, 1);
    check("rd_addr", rf_addr, 4'h5);
    send(8'h77);
    check("rd_drop_err", cmd_err, 1);
    check("rd_drop_busy", busy, 1);
    check("rd_en_pulse", rf_rd_en, 0);
    rf_rd_data = 8'h3C; rf_rd_vld = 1'b1;
    tick();
    rf_rd_vld = 1'b0;
    check("rd_no_early_tx", tx_vld, 0);
    tick();
    check("rd_tx_vld", tx_vld, 1);
    check("rd_tx_data", tx_data, 8'h3C);
    check("rd_idle", busy, 0);
    tick();
    check("rd_tx_count", n_tx, 1);

    // ALU CC,12,34,00 with result 0x0046 and 5 cycles of backpressure
    alu_out = 16'h0046;
    send(8'hCC);
    send(8'h12);
    check("opa_wr", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h0, 8'h12});
    send(8'h34);
    check("opb_wr", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h1, 8'h34});
    check("clkg_on", clkg_en, 1);
    send(8'h00);
    check("alu_en", alu_en, 1);
    check("alu_fun", alu_fun, 4'h0);
    tick();
    check("alu_en_pulse", alu_en, 0);
    fifo_full = 1'b1;
    alu_vld = 1'b1;
    tick();
    alu_vld = 1'b0;
    check("clkg_off", clkg_en, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_push_full", tx_vld, 0);
    end
    fifo_full = 1'b0;
    tick();
    check("alu_chunk0", {tx_vld, tx_data}, {1'b1, 8'h46});
    tick();
    check("alu_chunk1", {tx_vld, tx_data}, {1'b1, 8'h00});
    check("alu_idle", busy, 0);
    tick();
    check("alu_tx_done", tx_vld, 0);
    check("tx_total", n_tx, 3);
    check("wr_total", n_wr, 3);

    // Unknown opcode
    send(8'h77);
    check("bad_op_err", cmd_err, 1);
    check("bad_op_idle", busy, 0);
    tick();
    check("err_pulse", cmd_err, 0);

    // Timeout: AA,05 then silence; error expected 1024 cycles after the address frame
    wr_snap = n_wr; alu_snap = n_alu;
    send(8'hAA);
    send(8'h05);
    err_at = -1;
    for (int i = 1; i <= 1100 && err_at < 0; i++) begin
      tick();
      if (cmd_err) err_at = i;
    end
    check("tmo_cycle", err_at, 1024);
    check("tmo_idle", busy, 0);
    tick();
    check("tmo_no_wr", n_wr, wr_snap);
    check("tmo_no_alu", n_alu, alu_snap);

    // Reset mid-command discards state and clears the ALU clock gate
    send(8'hCC);
    send(8'h12);
    send(8'h34);
    check("mid_clkg", clkg_en, 1);
    rst = 1'b1;
    #2;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_clkg", clkg_en, 0);
    tick();
    rst = 1'b0;
    tick();
    send(8'hAA);
    send(8'h09);
    send(8'h5A);
    check("post_rst_wr", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h9, 8'h5A});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
